// File: rtl/cook_sequencer.sv
// ---------------------------------------------------------------------------
// cook_sequencer
//
// Two-stage cooking program sequencer with power-level duty cycling. Runs a
// stage-1 time at a stage-1 power, then an optional stage-2 time at a stage-2
// power, counting whole seconds down and pulsing `done` on completion.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per second (>= 2)
//
// Ports
//   clock          in   system clock, rising edge
//   clearn         in   asynchronous reset, active low
//   startn         in   start/resume button, active low (sync, debounced)
//   stopn          in   stop/cancel button, active low (sync, debounced)
//   door_closed    in   1 = door closed
//   stage1_secs    in   stage-1 seconds (clamped to 599)
//   stage1_power   in   stage-1 power 1..10 (0 or >10 means 10)
//   stage2_en      in   enables stage 2
//   stage2_secs    in   stage-2 seconds (clamped to 599)
//   stage2_power   in   stage-2 power (same mapping as stage 1)
//   mag_on         out  magnetron drive (door gate is combinational)
//   running        out  1 in RUN1/RUN2
//   paused         out  1 in PAUSE
//   stage          out  0 idle, 1 stage 1, 2 stage 2 (held in PAUSE)
//   remaining      out  seconds left in the current stage
//   done           out  one-cycle completion pulse
//   dbg_state      out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic [9:0] stage1_secs,
    input  logic [3:0] stage1_power,
    input  logic       stage2_en,
    input  logic [9:0] stage2_secs,
    input  logic [3:0] stage2_power,
    output logic       mag_on,
    output logic       running,
    output logic       paused,
    output logic [1:0] stage,
    output logic [9:0] remaining,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam int            PW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [9:0]    SECS_MAX  = 10'd599;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN1  = 3'd1,
        S_RUN2  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [PW-1:0] r_presc,     w_presc_nxt;
    logic [3:0]    r_window,    w_window_nxt;
    logic [9:0]    r_remaining, w_remaining_nxt;
    logic [1:0]    r_stage,     w_stage_nxt;
    logic          r_start_q;
    logic          r_stop_q;

    logic       w_start_press;
    logic       w_stop_press;
    logic       w_tick;
    logic       w_in_run;
    logic [9:0] w_s1_secs;
    logic [9:0] w_s2_secs;
    logic [3:0] w_s1_pwr;
    logic [3:0] w_s2_pwr;
    logic [3:0] w_cur_pwr;

    // A press is the falling edge of the button; holding it gives one press.
    assign w_start_press = r_start_q & ~startn;
    assign w_stop_press  = r_stop_q  & ~stopn;

    assign w_s1_secs = (stage1_secs > SECS_MAX) ? SECS_MAX : stage1_secs;
    assign w_s2_secs = (stage2_secs > SECS_MAX) ? SECS_MAX : stage2_secs;
    assign w_s1_pwr  = (stage1_power == 4'd0 || stage1_power > 4'd10) ? 4'd10 : stage1_power;
    assign w_s2_pwr  = (stage2_power == 4'd0 || stage2_power > 4'd10) ? 4'd10 : stage2_power;
    assign w_cur_pwr = (r_stage == 2'd2) ? w_s2_pwr : w_s1_pwr;

    assign w_in_run = (r_state == S_RUN1) || (r_state == S_RUN2);
    assign w_tick   = (r_presc == PRESC_MAX);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_window    <= '0;
            r_remaining <= '0;
            r_stage     <= '0;
            r_start_q   <= 1'b1;
            r_stop_q    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_window    <= w_window_nxt;
            r_remaining <= w_remaining_nxt;
            r_stage     <= w_stage_nxt;
            r_start_q   <= startn;
            r_stop_q    <= stopn;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_presc_nxt     = r_presc;
        w_window_nxt    = r_window;
        w_remaining_nxt = r_remaining;
        w_stage_nxt     = r_stage;

        case (r_state)
            S_IDLE: begin
                // Stop has priority over a simultaneous start, even here.
                if (w_start_press && !w_stop_press && door_closed && (w_s1_secs != 10'd0)) begin
                    w_state_nxt     = S_RUN1;
                    w_stage_nxt     = 2'd1;
                    w_remaining_nxt = w_s1_secs;
                    w_presc_nxt     = '0;
                    w_window_nxt    = '0;
                end
            end

            S_RUN1, S_RUN2: begin
                // Pausing takes priority over a coincident tick: counters freeze.
                if (w_stop_press || !door_closed) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_remaining == 10'd1) begin
                        if ((r_state == S_RUN1) && stage2_en && (w_s2_secs != 10'd0)) begin
                            w_state_nxt     = S_RUN2;
                            w_stage_nxt     = 2'd2;
                            w_remaining_nxt = w_s2_secs;
                            w_window_nxt    = '0;
                        end else begin
                            w_state_nxt     = S_DONE;
                            w_remaining_nxt = '0;
                        end
                    end else begin
                        w_remaining_nxt = r_remaining - 10'd1;
                        w_window_nxt    = (r_window == 4'd9) ? 4'd0 : r_window + 4'd1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            S_PAUSE: begin
                if (w_stop_press) begin
                    w_state_nxt     = S_IDLE;
                    w_stage_nxt     = '0;
                    w_remaining_nxt = '0;
                    w_presc_nxt     = '0;
                    w_window_nxt    = '0;
                end else if (w_start_press && door_closed) begin
                    w_state_nxt = (r_stage == 2'd2) ? S_RUN2 : S_RUN1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_stage_nxt = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Door gate is deliberately combinational so an opening door cuts power
    // in the same cycle.
    assign mag_on    = w_in_run && (r_window < w_cur_pwr) && door_closed;
    assign running   = w_in_run;
    assign paused    = (r_state == S_PAUSE);
    assign done      = (r_state == S_DONE);
    assign stage     = r_stage;
    assign remaining = r_remaining;
    assign dbg_state = r_state;

endmodule
